// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronise, debounce and press/release/long-press classification
module button_conditioner #(
  parameter int NUM_BTN = 2,
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int LONG_PRESS_CYCLES = 24_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_held_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT} state_t;
  logic [NUM_BTN-1:0] s1, s2;
  always_ff @(posedge clock) begin
    s1 <= reset ? '0 : btn_raw;
    s2 <= reset ? '0 : s1;
  end
  for (genvar c = 0; c < NUM_BTN; c++) begin : g_ch
    state_t state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic level, press, rel, lng, held;
    logic level_n, press_n, rel_n, lng_n, held_n;
    always_ff @(posedge clock) begin
      if (reset) begin
        state <= IDLE;
        dcnt  <= '0;
        hcnt  <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
        held  <= 1'b0;
      end else begin
        state <= state_n;
        dcnt  <= dcnt_n;
        hcnt  <= hcnt_n;
        level <= level_n;
        press <= press_n;
        rel   <= rel_n;
        lng   <= lng_n;
        held  <= held_n;
      end
    end
    always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      level_n = level;
      press_n = 1'b0;
      rel_n   = 1'b0;
      lng_n   = 1'b0;
      held_n  = held;
      case (state)
        IDLE: begin
          if (s2[c]) begin
            state_n = PRESS_WAIT;
            dcnt_n  = DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s2[c]) begin
            state_n = IDLE;
            dcnt_n  = '0;
          end else if (dcnt == D_MAX) begin
            state_n = PRESSED;
            level_n = 1'b1;
            press_n = 1'b1;
            hcnt_n  = '0;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
        PRESSED: begin
          if (hcnt == H_LAST) begin
            state_n = LONG_HELD;
            lng_n   = 1'b1;
            held_n  = 1'b1;
            hcnt_n  = hcnt + HW'(1);
          end else if (!s2[c]) begin
            state_n = RELEASE_WAIT;
            dcnt_n  = DW'(1);
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end
        LONG_HELD: begin
          if (!s2[c]) begin
            state_n = RELEASE_WAIT;
            dcnt_n  = DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s2[c]) begin
            state_n = held ? LONG_HELD : PRESSED;
            dcnt_n  = '0;
          end else if (dcnt == D_MAX) begin
            state_n = IDLE;
            level_n = 1'b0;
            rel_n   = 1'b1;
            held_n  = 1'b0;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
    assign btn_level[c]     = level;
    assign btn_press[c]     = press;
    assign btn_release[c]   = rel;
    assign btn_long[c]      = lng;
    assign btn_held_long[c] = held;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input conditioning stage directly upstream of the LED dimmer/controller. It takes raw asynchronous push-button pins and produces the clean levels that drive its buton1/buton2 inputs.
- Per channel it synchronises, debounces, and classifies presses. It emits a clean level, one-cycle press/release/long-press event pulses, and a long-hold level.
- One instance serves all board buttons; channels are fully independent.

Parameters:
NUM_BTN, 2, number of independent button channels
DEBOUNCE_CYCLES, 120_000, consecutive stable synchronised samples required to accept a level change (10 ms at 12 MHz); legal range >= 1
LONG_PRESS_CYCLES, 24_000_000, cycles from press acceptance to long-press event (2 s at 12 MHz); must be > DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_raw  input  NUM_BTN  raw button pins, asynchronous, active-high (1 = pressed)
btn_level  output  NUM_BTN  debounced button level; connects to downstream buton1/buton2
btn_press  output  NUM_BTN  one-cycle pulse on accepted press
btn_release  output  NUM_BTN  one-cycle pulse on accepted release
btn_long  output  NUM_BTN  one-cycle pulse when a press reaches LONG_PRESS_CYCLES
btn_held_long  output  NUM_BTN  high from btn_long pulse until accepted release

Behaviour:
- Reset (reset=1 sampled on edge):
  - All outputs 0, synchroniser flops 0, counters 0, every FSM in IDLE.
  - Reset mid-press drops btn_level immediately, with no release pulse.
- Synchroniser: per bit, 2-flop chain btn_raw -> s1 -> s2. Only s2 is used downstream.
- Per-channel FSM states: IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1). Hold counter: width $clog2(LONG_PRESS_CYCLES+1).
- IDLE:
  - s2=1 -> PRESS_WAIT, debounce count = 1.
  - Otherwise stay.
- PRESS_WAIT:
  - s2=0 -> IDLE, count cleared, no output.
  - s2=1 and count = DEBOUNCE_CYCLES -> PRESSED; btn_level <= 1; btn_press pulses for that one cycle; hold count = 0.
  - Otherwise count++.
  - With DEBOUNCE_CYCLES=1, acceptance occurs on the edge after entering PRESS_WAIT.
- Press latency: a clean raw rising edge gives btn_level high exactly 2 + DEBOUNCE_CYCLES cycles after the first edge that samples btn_raw=1.
- PRESSED:
  - Hold count increments every cycle.
  - When hold count reaches LONG_PRESS_CYCLES-1 -> LONG_HELD; btn_long pulses one cycle; btn_held_long <= 1.
  - s2=0 -> RELEASE_WAIT, debounce count = 1, hold count frozen.
- LONG_HELD:
  - Hold count saturates; no further btn_long pulses.
  - s2=0 -> RELEASE_WAIT, debounce count = 1.
- RELEASE_WAIT (btn_level stays 1 throughout):
  - s2=1 -> return to PRESSED if btn_held_long=0, else LONG_HELD; debounce count cleared, hold count resumes from its frozen value.
  - s2=0 and count = DEBOUNCE_CYCLES -> IDLE; btn_level <= 0; btn_release pulses; btn_held_long <= 0.
  - Otherwise count++.
- Pulse rules:
  - btn_press and btn_release never assert in the same cycle on one channel.
  - btn_long asserts at most once per accepted press.
  - Pulses are exactly 1 cycle wide.
- Release timing:
  - Release accepted while in PRESSED: no btn_long.
  - Release during the long-press crossing: the state transition in the current cycle wins, so if the hold count hits the threshold on the same edge s2 first reads 0, btn_long still fires, then RELEASE_WAIT follows.
- All outputs are registered; no combinational path from btn_raw.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_BTN=2):
- Reset held 3 cycles with btn_raw=2'b11 -> all outputs 0 during reset; after release, btn_level[0] rises exactly 6 cycles after the first edge sampling btn_raw=1, with btn_press[0] high for 1 cycle.
- Bounce on btn_raw[0]: 1,1,0,1,1,1,1 over 7 cycles -> the first partial run is rejected; btn_level[0] rises 6 cycles after the final rise; exactly one btn_press.
- Glitch: btn_raw[1] high for 3 cycles then low -> btn_level[1] stays 0; no pulses.
- Long press: hold btn_raw[0]=1 for 40 cycles -> btn_long[0] pulses once 20 cycles after btn_press[0]; btn_held_long[0]=1 until btn_level falls. On release, btn_release pulses and btn_held_long clears in the same cycle.
- Release bounce: while pressed, btn_raw[0] goes 0 for 2 cycles then 1 -> btn_level stays 1; no release pulse; a subsequent 4-cycle stable low gives a release 6 cycles after the raw fall.
- Channel independence plus reset mid-press: press ch0, then ch1 staggered by 2 cycles -> pulses offset by 2 cycles. Assert reset while both are high -> both btn_level clear on the next edge with no btn_release.
